// File: rtl/mem_stage_access.sv
// MEM stage of the 16-bit MIPS core: data-memory req/ready access, pipeline stall and MEM/WB register.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage_access #(
  parameter int unsigned ADDR_W = 16
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              zero,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [15:0]       aluresult,
  input  logic [15:0]       data_to_mem,
  input  logic [3:0]        regdst,
  input  logic [15:0]       dm_rdata,
  input  logic              dm_ready,
  output logic              pcsrc,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [15:0]       dm_wdata,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [15:0]       wb_readdata,
  output logic [15:0]       wb_aluresult,
  output logic [3:0]        wb_regdst,
  output logic              dm_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e state_q;
  logic   mem_op;
  logic   timeout;

  assign mem_op = memread | memwrite;
  assign pcsrc  = branch & zero;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout = (state_q == ACCESS) && !dm_ready && (cnt_q == CNT_LAST);

  // Watchdog: counts unanswered ACCESS cycles; error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dm_err <= 1'b0;
    end else begin
      if (state_q == IDLE && mem_op) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS && !dm_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout) begin
        dm_err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign dm_err  = 1'b0;
`endif

  // Release the pipeline in the cycle the access retires (or is abandoned).
  always_comb begin
    stall = 1'b0;
    if (state_q == IDLE) begin
      stall = mem_op;
    end else begin
      stall = !dm_ready && !timeout;
    end
  end

  // Access FSM with registered memory request and MEM/WB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_readdata  <= '0;
      wb_aluresult <= '0;
      wb_regdst    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q      <= ACCESS;
            dm_req       <= 1'b1;
            dm_we        <= memwrite;
            dm_addr      <= aluresult[ADDR_W-1:0];
            dm_wdata     <= data_to_mem;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_aluresult <= '0;
            wb_regdst    <= '0;
          end else begin
            wb_regwrite  <= regwrite;
            wb_memtoreg  <= memtoreg;
            wb_aluresult <= aluresult;
            wb_regdst    <= regdst;
          end
        end
        ACCESS: begin
          if (dm_ready) begin
            state_q      <= IDLE;
            dm_req       <= 1'b0;
            wb_regwrite  <= regwrite;
            wb_memtoreg  <= memtoreg;
            wb_aluresult <= aluresult;
            wb_regdst    <= regdst;
            if (!dm_we) begin
              wb_readdata <= dm_rdata;
            end
          end else begin
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_aluresult <= '0;
            wb_regdst    <= '0;
            if (timeout) begin
              state_q     <= IDLE;
              dm_req      <= 1'b0;
              wb_readdata <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed self-checking bench for mem_stage_access (timeout scenario built when MEM_TIMEOUT_EN is defined).
module tb_mem_stage_access;

  logic        clk;
  logic        rst_n;
  logic        branch, memread, memwrite, zero, regwrite, memtoreg;
  logic [15:0] aluresult, data_to_mem, dm_rdata;
  logic [3:0]  regdst;
  logic        dm_ready;
  logic        pcsrc, stall, dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata;
  logic        wb_regwrite, wb_memtoreg;
  logic [15:0] wb_readdata, wb_aluresult;
  logic [3:0]  wb_regdst;
  logic        dm_err;

  int checks   = 0;
  int failures = 0;
  int stall_cnt;
  int req_cnt;

  mem_stage_access #(
    .ADDR_W(16)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .memread(memread),
    .memwrite(memwrite), .zero(zero), .regwrite(regwrite), .memtoreg(memtoreg),
    .aluresult(aluresult), .data_to_mem(data_to_mem), .regdst(regdst),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .pcsrc(pcsrc), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult),
    .wb_regdst(wb_regdst), .dm_err(dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    branch = 0; memread = 0; memwrite = 0; zero = 0; regwrite = 0; memtoreg = 0;
    aluresult = 0; data_to_mem = 0; regdst = 0; dm_rdata = 0; dm_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_dm_req", 16'(dm_req), 16'h0);
    check("rst_wb_regwrite", 16'(wb_regwrite), 16'h0);
    check("rst_wb_readdata", wb_readdata, 16'h0);
    check("rst_stall", 16'(stall), 16'h0);
    check("rst_dm_err", 16'(dm_err), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain ALU op passes straight through MEM/WB
    regwrite = 1; aluresult = 16'h1234; regdst = 4'd5;
    #1 check("alu_stall", 16'(stall), 16'h0);
    tick();
    check("alu_wb_regwrite", 16'(wb_regwrite), 16'h1);
    check("alu_wb_aluresult", wb_aluresult, 16'h1234);
    check("alu_wb_regdst", 16'(wb_regdst), 16'h5);
    check("alu_dm_req", 16'(dm_req), 16'h0);

    // Load, ready on the third ACCESS cycle, branch taken throughout
    memread = 1; memtoreg = 1; aluresult = 16'h0040; regdst = 4'd3;
    branch = 1; zero = 1;
    #1;
    check("ld_idle_stall", 16'(stall), 16'h1);
    check("ld_idle_pcsrc", 16'(pcsrc), 16'h1);
    stall_cnt = int'(stall);
    req_cnt = 0;
    tick();
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc == 3) begin
        dm_ready = 1; dm_rdata = 16'hBEEF;
      end
      #1;
      stall_cnt += int'(stall);
      req_cnt += int'(dm_req);
      check("ld_dm_addr", dm_addr, 16'h0040);
      check("ld_dm_we", 16'(dm_we), 16'h0);
      check("ld_pcsrc", 16'(pcsrc), 16'h1);
      if (cyc < 3) check("ld_bubble", 16'(wb_regwrite), 16'h0);
      tick();
    end
    check("ld_stall_cycles", 16'(stall_cnt), 16'd3);
    check("ld_req_cycles", 16'(req_cnt), 16'd3);
    check("ld_wb_readdata", wb_readdata, 16'hBEEF);
    check("ld_wb_regwrite", 16'(wb_regwrite), 16'h1);
    check("ld_wb_memtoreg", 16'(wb_memtoreg), 16'h1);
    check("ld_wb_aluresult", wb_aluresult, 16'h0040);
    check("ld_wb_regdst", 16'(wb_regdst), 16'h3);
    check("ld_dm_req_drop", 16'(dm_req), 16'h0);

    // dm_ready while IDLE must be ignored
    memread = 0; memtoreg = 0; aluresult = 16'h0055; regdst = 4'd1;
    dm_rdata = 16'h5555;
    tick();
    check("idle_rdy_readdata", wb_readdata, 16'hBEEF);
    check("idle_rdy_dm_req", 16'(dm_req), 16'h0);
    check("idle_rdy_aluresult", wb_aluresult, 16'h0055);

    // Store, ready on first ACCESS cycle; branch not taken
    dm_ready = 0; memwrite = 1; regwrite = 0; aluresult = 16'h0010;
    data_to_mem = 16'hA5A5; regdst = 4'd0; zero = 0;
    #1;
    check("st_idle_stall", 16'(stall), 16'h1);
    check("st_pcsrc_nz", 16'(pcsrc), 16'h0);
    tick();
    check("st_dm_req", 16'(dm_req), 16'h1);
    check("st_dm_we", 16'(dm_we), 16'h1);
    check("st_dm_wdata", dm_wdata, 16'hA5A5);
    check("st_dm_addr", dm_addr, 16'h0010);
    dm_ready = 1; dm_rdata = 16'h1111;
    #1 check("st_ready_stall", 16'(stall), 16'h0);
    tick();
    check("st_dm_req_drop", 16'(dm_req), 16'h0);
    check("st_wb_readdata", wb_readdata, 16'hBEEF);
    check("st_wb_regwrite", 16'(wb_regwrite), 16'h0);
    check("st_wb_aluresult", wb_aluresult, 16'h0010);

    // Back-to-back op with read+write both set: IDLE gap, then write wins
    dm_ready = 0; memread = 1; memwrite = 1; aluresult = 16'h0022;
    data_to_mem = 16'h0F0F;
    #1;
    check("b2b_gap_dm_req", 16'(dm_req), 16'h0);
    check("b2b_gap_stall", 16'(stall), 16'h1);
    tick();
    check("both_dm_we", 16'(dm_we), 16'h1);
    check("both_dm_req", 16'(dm_req), 16'h1);
    check("both_dm_addr", dm_addr, 16'h0022);
    dm_ready = 1;
    tick();
    check("both_dm_req_drop", 16'(dm_req), 16'h0);
    check("both_wb_readdata", wb_readdata, 16'hBEEF);

    // Reset asserted in the middle of an access
    dm_ready = 0; memwrite = 0; memread = 1; regwrite = 1; aluresult = 16'h0080;
    tick();
    check("rstmid_dm_req_pre", 16'(dm_req), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_dm_req", 16'(dm_req), 16'h0);
    check("rstmid_dm_addr", dm_addr, 16'h0000);
    check("rstmid_wb_regwrite", 16'(wb_regwrite), 16'h0);
    check("rstmid_wb_aluresult", wb_aluresult, 16'h0000);
    check("rstmid_wb_readdata", wb_readdata, 16'h0000);
    memread = 0;
    #1 check("rstmid_idle_stall", 16'(stall), 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    regwrite = 0; aluresult = 16'h0009; dm_ready = 1; dm_rdata = 16'h7777;
    tick();
    check("rstmid_no_retire_rd", wb_readdata, 16'h0000);
    check("rstmid_no_retire_req", 16'(dm_req), 16'h0);
    check("rstmid_idle_alu", wb_aluresult, 16'h0009);
    check("no_err_default", 16'(dm_err), 16'h0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog abandons an access that never gets ready
    dm_ready = 0; memread = 1; regwrite = 1; aluresult = 16'h0044; regdst = 4'd2;
    tick();
    req_cnt = 0;
    stall_cnt = 0;
    for (int i = 0; i < 20 && dm_req; i++) begin
      req_cnt++;
      stall_cnt += int'(stall);
      tick();
    end
    check("to_req_cycles", 16'(req_cnt), 16'd8);
    check("to_stall_cycles", 16'(stall_cnt), 16'd7);
    check("to_dm_err", 16'(dm_err), 16'h1);
    check("to_wb_regwrite", 16'(wb_regwrite), 16'h0);
    check("to_wb_readdata", wb_readdata, 16'h0000);
    memread = 0; aluresult = 16'h0066;
    tick();
    check("to_next_alu", wb_aluresult, 16'h0066);
    check("to_next_regwrite", 16'(wb_regwrite), 16'h1);
    check("to_err_sticky", 16'(dm_err), 16'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Consumer side of the EX/MEM pipeline register in the 16-bit MIPS core.
- Takes the EX/MEM outputs (control bits, ALU result, store data, destination register) and runs any load/store on the data-memory bus with a req/ready handshake.
- Stalls the pipeline while an access is outstanding.
- Produces the registered MEM/WB values and the branch-taken select.

Parameters:
- ADDR_W, 16, data-memory address width (low bits of aluresult).
- TIMEOUT_CYCLES, 64, ACCESS-state watchdog limit (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- branch  input  1  EX/MEM branch control
- memread  input  1  EX/MEM load request
- memwrite  input  1  EX/MEM store request
- zero  input  1  EX/MEM ALU zero flag
- regwrite  input  1  EX/MEM register-write control
- memtoreg  input  1  EX/MEM writeback-select control
- aluresult  input  16  ALU result / memory address
- data_to_mem  input  16  store data
- regdst  input  4  destination register index
- dm_rdata  input  16  memory read data
- dm_ready  input  1  memory completes the current request
- pcsrc  output  1  branch taken = branch & zero (combinational)
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational)
- dm_req  output  1  request valid (registered)
- dm_we  output  1  1 = write, 0 = read (registered)
- dm_addr  output  ADDR_W  request address (registered)
- dm_wdata  output  16  write data (registered)
- wb_regwrite  output  1  MEM/WB regwrite
- wb_memtoreg  output  1  MEM/WB memtoreg
- wb_readdata  output  16  MEM/WB load data
- wb_aluresult  output  16  MEM/WB ALU result
- wb_regdst  output  4  MEM/WB destination register
- dm_err  output  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, async): every registered output is 0 and state = IDLE. dm_req drops immediately, including mid-access; the aborted access produces no MEM/WB write.
- FSM states: IDLE, ACCESS.
- IDLE, memread=0 and memwrite=0:
  - MEM/WB registers load {regwrite, memtoreg, aluresult, regdst} each edge (latency 1).
  - wb_readdata holds its value.
  - stall = 0.
- IDLE, memread or memwrite = 1:
  - stall = 1.
  - At the edge: state -> ACCESS, dm_req <= 1, dm_we <= memwrite, dm_addr <= aluresult[ADDR_W-1:0], dm_wdata <= data_to_mem.
  - MEM/WB loads a bubble (wb_regwrite = 0, other fields 0).
  - If both memread and memwrite are 1, the write wins.
- ACCESS:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable.
  - stall = !dm_ready.
  - dm_ready = 0: MEM/WB loads a bubble each edge.
  - dm_ready = 1 at the edge: wb_readdata <= dm_rdata (reads only; unchanged on writes), other MEM/WB fields load from the EX/MEM inputs, dm_req <= 0, state -> IDLE.
- Stall is 0 in the dm_ready cycle, so EX/MEM advances at the same edge the access retires.
- Minimum memory-op latency: 2 cycles (ready on the first ACCESS cycle).
- Back-to-back memory ops: the next op enters ACCESS one cycle after the previous one retires (one IDLE cycle between requests).
- dm_ready outside ACCESS is ignored.
- pcsrc = branch & zero, unaffected by stall. The hazard unit qualifies it with !stall.
- EX/MEM inputs are stable while stall = 1. The block does not re-sample them during ACCESS except at retirement.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without dm_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready: dm_req <= 0, state -> IDLE, dm_err <= 1 (sticky until reset).
  - MEM/WB gets a bubble with wb_readdata = 0.
  - stall = 0 in that final cycle.
- Undefined:
  - ACCESS waits indefinitely.
  - dm_err is tied to 0 and no counter is synthesized.

Test Plan:
- Reset release, ALU op (regwrite=1, aluresult=0x1234, regdst=5, no mem) -> next edge: wb_regwrite=1, wb_aluresult=0x1234, wb_regdst=5, stall=0, dm_req=0.
- Load: memread=1, memtoreg=1, aluresult=0x0040, dm_ready after 3 ACCESS cycles with dm_rdata=0xBEEF:
  - dm_req high 3 cycles at dm_addr=0x0040, dm_we=0.
  - stall high 3 cycles.
  - wb_regwrite=0 while stalled.
  - Then wb_readdata=0xBEEF, wb_regwrite=1.
- Store: memwrite=1, aluresult=0x0010, data_to_mem=0xA5A5, dm_ready on the first ACCESS cycle -> dm_we=1, dm_wdata=0xA5A5, total stall 1 cycle, wb_readdata unchanged.
- branch=1, zero=1 during a load stall -> pcsrc=1 throughout. With zero=0 -> pcsrc=0.
- rst_n pulsed low mid-ACCESS -> dm_req=0 immediately, all wb_* = 0, state IDLE, no retirement when dm_ready later asserts.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, dm_ready held 0 -> dm_req drops after 8 ACCESS cycles, dm_err=1 and stays 1, wb_regwrite=0, next instruction proceeds.
